// File: rtl/ex_stage_md.sv
// ----------------------------------------------------------------------------
// ex_stage_md -- execute stage of the pipelined MIPS core.
//
// Purpose:
//   Forwarding muxes for both operands, destination register select, a
//   combinational ALU and a multi-cycle multiply/divide unit (MDU) that owns
//   the architectural HI/LO registers. The MDU reports busy/start so the
//   hazard unit can hold later MDU instructions in D.
//
// Optional feature macro: MDU_DIV_EN
//   defined   : div/divu run for DIV_CYCLES and write HI/LO.
//   undefined : div/divu are no-ops. There is no DIV state and no divider.
//
// Parameters:
//   WIDTH       datapath width (>= 8, even)
//   MUL_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES  busy cycles for div/divu (>= 1)
//
// Ports:
//   clk, reset_n            rising-edge clock, synchronous active-low reset
//   rd1_e, rd2_e            register-file operands
//   result_w, alu_out_m     forwarded values from W and M
//   fwd_a_e, fwd_b_e        0/3 = register file, 1 = result_w, 2 = alu_out_m
//   alu_src_e, ext_imm_e    ALU B select and the extended immediate
//   alu_ctrl_e              ALU operation
//   rs_e, rt_e, rd_e        register specifiers
//   reg_dst_e               0 = rd, 1 = rt, 2 = r31
//   md_op_e                 MDU operation of the instruction in E
//   md_use_d                instruction in D is an MDU operation
//   valid_e                 E holds a real instruction (0 = bubble)
//   ex_out_e                hi for mfhi, lo for mflo, otherwise ALU result
//   write_data_e            forwarded B, taken before the immediate mux
//   write_reg_e             destination register
//   hi, lo                  architectural HI/LO
//   md_busy, md_start       MDU in flight / MDU op starting this cycle
//   md_stall                hold the MDU instruction in D
// ----------------------------------------------------------------------------
module ex_stage_md #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rd1_e,
  input  logic [WIDTH-1:0] rd2_e,
  input  logic [WIDTH-1:0] result_w,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic [1:0]       fwd_a_e,
  input  logic [1:0]       fwd_b_e,
  input  logic             alu_src_e,
  input  logic [WIDTH-1:0] ext_imm_e,
  input  logic [3:0]       alu_ctrl_e,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       reg_dst_e,
  input  logic [3:0]       md_op_e,
  input  logic             md_use_d,
  input  logic             valid_e,
  output logic [WIDTH-1:0] ex_out_e,
  output logic [WIDTH-1:0] write_data_e,
  output logic [4:0]       write_reg_e,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_busy,
  output logic             md_start,
  output logic             md_stall
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} md_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} md_state_t;
`endif

  // rs_e only matters to the hazard unit; it is accepted here for a uniform
  // pipeline-register interface.
  logic unused_ok;
  assign unused_ok = ^rs_e;

  // ---------------------------------------------------------------- forwarding
  logic [WIDTH-1:0] src_a, src_b, alu_b;

  always_comb begin
    case (fwd_a_e)
      2'd1:    src_a = result_w;
      2'd2:    src_a = alu_out_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      2'd1:    src_b = result_w;
      2'd2:    src_b = alu_out_m;
      default: src_b = rd2_e;
    endcase
  end

  assign alu_b        = alu_src_e ? ext_imm_e : src_b;
  assign write_data_e = src_b;

  always_comb begin
    case (reg_dst_e)
      2'd1:    write_reg_e = rt_e;
      2'd2:    write_reg_e = 5'd31;
      default: write_reg_e = rd_e;
    endcase
  end

  // ----------------------------------------------------------------------- ALU
  logic [WIDTH-1:0] alu_y;

  always_comb begin
    alu_y = '0;
    case (alu_ctrl_e)
      4'd0: alu_y = src_a + alu_b;
      4'd1: alu_y = src_a - alu_b;
      4'd2: alu_y = src_a & alu_b;
      4'd3: alu_y = src_a | alu_b;
      4'd4: alu_y = src_a ^ alu_b;
      4'd5: alu_y = ~(src_a | alu_b);
      4'd6: alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(alu_b))};
      4'd7: alu_y = {{(WIDTH-1){1'b0}}, (src_a < alu_b)};
      4'd8: alu_y = alu_b << 16;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    case (md_op_e)
      MD_MFHI: ex_out_e = hi;
      MD_MFLO: ex_out_e = lo;
      default: ex_out_e = alu_y;
    endcase
  end

  // ----------------------------------------------------------------------- MDU
  md_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [WIDTH-1:0] opa_reg, opa_next, opb_reg, opb_next;
  logic             sgn_reg, sgn_next;

  logic is_mul_op, is_div_op;
  assign is_mul_op = (md_op_e == MD_MULT) || (md_op_e == MD_MULTU);
`ifdef MDU_DIV_EN
  assign is_div_op = (md_op_e == MD_DIV) || (md_op_e == MD_DIVU);
`else
  assign is_div_op = 1'b0;
`endif

  assign md_busy  = (state_reg != IDLE);
  assign md_start = valid_e && (is_mul_op || is_div_op) && !md_busy;
  assign md_stall = md_use_d && (md_start || md_busy);
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  // Full-width products: sign- or zero-extend to 2*WIDTH first so the low
  // 2*WIDTH bits of the product are the exact signed/unsigned result.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{opa_reg[WIDTH-1]}}, opa_reg} * {{WIDTH{opb_reg[WIDTH-1]}}, opb_reg};
  assign prod_u = {{WIDTH{1'b0}}, opa_reg} * {{WIDTH{1'b0}}, opb_reg};

`ifdef MDU_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] q_s, r_s, q_u, r_u;

  // Guarded so divide-by-zero never produces X; the result is then discarded.
  // The most-negative / -1 case overflows, so it is pinned explicitly.
  always_comb begin
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (opb_reg != '0) begin
      q_u = opa_reg / opb_reg;
      r_u = opa_reg % opb_reg;
      if ((opa_reg == MOST_NEG) && (opb_reg == {WIDTH{1'b1}})) begin
        q_s = MOST_NEG;
        r_s = '0;
      end else begin
        q_s = $unsigned($signed(opa_reg) / $signed(opb_reg));
        r_s = $unsigned($signed(opa_reg) % $signed(opb_reg));
      end
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    sgn_next   = sgn_reg;
    case (state_reg)
      IDLE: begin
        if (md_start) begin
          opa_next = src_a;
          opb_next = src_b;
          sgn_next = (md_op_e == MD_MULT) || (md_op_e == MD_DIV);
          if (is_mul_op) begin
            state_next = MUL;
            cnt_next   = CW'(MUL_CYCLES);
          end
`ifdef MDU_DIV_EN
          else begin
            state_next = DIV;
            cnt_next   = CW'(DIV_CYCLES);
          end
`endif
        end else if (valid_e && (md_op_e == MD_MTHI)) begin
          hi_next = src_a;
        end else if (valid_e && (md_op_e == MD_MTLO)) begin
          lo_next = src_a;
        end
      end
      MUL: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          {hi_next, lo_next} = sgn_reg ? prod_s : prod_u;
          state_next = IDLE;
        end
      end
`ifdef MDU_DIV_EN
      DIV: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          if (opb_reg != '0) begin
            hi_next = sgn_reg ? r_s : r_u;
            lo_next = sgn_reg ? q_s : q_u;
          end
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      sgn_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      sgn_reg   <= sgn_next;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_md -- directed self-checking bench for ex_stage_md (WIDTH=32,
// MUL_CYCLES=5, DIV_CYCLES=10). Expected values are hand-computed constants.
// Inputs are driven 1 time unit after the rising edge and outputs are checked
// 2 time units after it. Divide expectations follow MDU_DIV_EN.
// ----------------------------------------------------------------------------
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rd1_e, rd2_e, result_w, alu_out_m, ext_imm_e;
  logic [1:0]  fwd_a_e, fwd_b_e, reg_dst_e;
  logic        alu_src_e, md_use_d, valid_e;
  logic [3:0]  alu_ctrl_e, md_op_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic [31:0] ex_out_e, write_data_e, hi, lo;
  logic [4:0]  write_reg_e;
  logic        md_busy, md_start, md_stall;

  int checks = 0;
  int errors = 0;

  ex_stage_md #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .result_w(result_w), .alu_out_m(alu_out_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .alu_src_e(alu_src_e),
    .ext_imm_e(ext_imm_e), .alu_ctrl_e(alu_ctrl_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .reg_dst_e(reg_dst_e),
    .md_op_e(md_op_e), .md_use_d(md_use_d), .valid_e(valid_e),
    .ex_out_e(ex_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .hi(hi), .lo(lo), .md_busy(md_busy), .md_start(md_start), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Place an MDU instruction in E with A/B from the register file.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    fwd_a_e = 2'd0; fwd_b_e = 2'd0; alu_src_e = 1'b0;
    rd1_e = a; rd2_e = b; md_op_e = op; valid_e = 1'b1;
  endtask

  task automatic idle_inputs();
    md_op_e = 4'd0; valid_e = 1'b0; md_use_d = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    settle();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", md_busy); end
    $display("test_reset: hi=%h lo=%h busy=%b", hi, lo, md_busy);
  endtask

  task automatic test_alu();
    tick();
    fwd_a_e = 2'd2; alu_out_m = 32'd7; rd1_e = 32'd1; alu_src_e = 1'b1;
    ext_imm_e = 32'd5; alu_ctrl_e = 4'd0; settle();
    checks++; if (ex_out_e !== 32'd12) begin errors++; $display("FAIL alu_add_fwd got %h want %h", ex_out_e, 32'd12); end
    $display("test_alu: add fwd_m -> %h", ex_out_e);
    // A = result_w, B = alu_out_m via forwarding
    fwd_a_e = 2'd1; result_w = 32'd3; fwd_b_e = 2'd2; alu_out_m = 32'd10; alu_src_e = 1'b0;
    alu_ctrl_e = 4'd1; settle();
    checks++; if (ex_out_e !== 32'hFFFF_FFF9) begin errors++; $display("FAIL alu_sub got %h want %h", ex_out_e, 32'hFFFF_FFF9); end
    checks++; if (write_data_e !== 32'd10) begin errors++; $display("FAIL write_data got %h want %h", write_data_e, 32'd10); end
    $display("test_alu: sub -> %h wd=%h", ex_out_e, write_data_e);
    // signed vs unsigned compare: A=-1, B=1
    fwd_a_e = 2'd3; rd1_e = 32'hFFFF_FFFF; fwd_b_e = 2'd0; rd2_e = 32'd1;
    alu_ctrl_e = 4'd6; settle();
    checks++; if (ex_out_e !== 32'd1) begin errors++; $display("FAIL alu_slt got %h want %h", ex_out_e, 32'd1); end
    alu_ctrl_e = 4'd7; settle();
    checks++; if (ex_out_e !== 32'd0) begin errors++; $display("FAIL alu_sltu got %h want %h", ex_out_e, 32'd0); end
    alu_ctrl_e = 4'd5; rd1_e = 32'h0F0F_0000; rd2_e = 32'h0000_00F0; settle();
    checks++; if (ex_out_e !== 32'hF0F0_FF0F) begin errors++; $display("FAIL alu_nor got %h want %h", ex_out_e, 32'hF0F0_FF0F); end
    alu_ctrl_e = 4'd8; alu_src_e = 1'b1; ext_imm_e = 32'h0000_1234; settle();
    checks++; if (ex_out_e !== 32'h1234_0000) begin errors++; $display("FAIL alu_lui got %h want %h", ex_out_e, 32'h1234_0000); end
    alu_ctrl_e = 4'd12; settle();
    checks++; if (ex_out_e !== 32'h0) begin errors++; $display("FAIL alu_undef got %h want %h", ex_out_e, 32'h0); end
    $display("test_alu: slt/sltu/nor/lui/undef done");
    rd_e = 5'd9; rt_e = 5'd17; rs_e = 5'd3;
    reg_dst_e = 2'd0; settle();
    checks++; if (write_reg_e !== 5'd9) begin errors++; $display("FAIL wreg_rd got %0d want 9", write_reg_e); end
    reg_dst_e = 2'd1; settle();
    checks++; if (write_reg_e !== 5'd17) begin errors++; $display("FAIL wreg_rt got %0d want 17", write_reg_e); end
    reg_dst_e = 2'd2; settle();
    checks++; if (write_reg_e !== 5'd31) begin errors++; $display("FAIL wreg_31 got %0d want 31", write_reg_e); end
    $display("test_alu: write_reg select done");
    alu_ctrl_e = 4'd0; alu_src_e = 1'b0; reg_dst_e = 2'd0;
  endtask

  task automatic test_mult();
    tick();
    issue(4'd1, 32'hFFFF_FFFD, 32'd4); settle();
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL mult_start got %b want 1", md_start); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_t got %b want 0", md_busy); end
    tick(); idle_inputs(); settle();
    for (int i = 1; i <= 5; i++) begin
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mult_busy_%0d got %b want 1", i, md_busy); end
      tick(); settle();
    end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end got %b want 0", md_busy); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mult_lo got %h want %h", lo, 32'hFFFF_FFF4); end
    $display("test_mult: mult -3*4 hi=%h lo=%h", hi, lo);
    issue(4'd2, 32'hFFFF_FFFD, 32'd4);
    tick(); idle_inputs();
    repeat (5) tick();
    settle();
    checks++; if (hi !== 32'h0000_0003) begin errors++; $display("FAIL multu_hi got %h want %h", hi, 32'h3); end
    checks++; if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL multu_lo got %h want %h", lo, 32'hFFFF_FFF4); end
    md_op_e = 4'd7; valid_e = 1'b1; settle();
    checks++; if (ex_out_e !== 32'h3) begin errors++; $display("FAIL mfhi got %h want %h", ex_out_e, 32'h3); end
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL mfhi_start got %b want 0", md_start); end
    $display("test_mult: multu hi=%h lo=%h mfhi=%h", hi, lo, ex_out_e);
    idle_inputs();
  endtask

  task automatic test_div();
`ifdef MDU_DIV_EN
    tick();
    issue(4'd3, 32'hFFFF_FFF9, 32'd2); settle();
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL div_start got %b want 1", md_start); end
    tick(); idle_inputs(); settle();
    for (int i = 1; i <= 10; i++) begin
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy_%0d got %b want 1", i, md_busy); end
      tick(); settle();
    end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div_busy_end got %b want 0", md_busy); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    $display("test_div: -7/2 hi=%h lo=%h", hi, lo);
    issue(4'd3, 32'd5, 32'd0);
    tick(); idle_inputs(); settle();
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div0_busy got %b want 1", md_busy); end
    repeat (10) tick();
    settle();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div0_busy_end got %b want 0", md_busy); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div0_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    $display("test_div: 5/0 hi=%h lo=%h", hi, lo);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(); idle_inputs();
    repeat (10) tick();
    settle();
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h want %h", hi, 32'h0); end
    $display("test_div: min/-1 hi=%h lo=%h", hi, lo);
    issue(4'd4, 32'hFFFF_FFF9, 32'd2);
    tick(); idle_inputs();
    repeat (10) tick();
    settle();
    checks++; if (lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo got %h want %h", lo, 32'h7FFF_FFFC); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL divu_hi got %h want %h", hi, 32'h1); end
    $display("test_div: divu hi=%h lo=%h", hi, lo);
`else
    tick();
    issue(4'd3, 32'hFFFF_FFF9, 32'd2); settle();
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL nodiv_start got %b want 0", md_start); end
    tick(); idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      settle();
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL nodiv_busy_%0d got %b want 0", i, md_busy); end
      tick();
    end
    settle();
    checks++; if (hi !== 32'h3) begin errors++; $display("FAIL nodiv_hi got %h want %h", hi, 32'h3); end
    checks++; if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL nodiv_lo got %h want %h", lo, 32'hFFFF_FFF4); end
    $display("test_div: disabled, hi=%h lo=%h", hi, lo);
`endif
  endtask

  task automatic test_mthi_mtlo();
    tick();
    issue(4'd6, 32'd9, 32'd0);
    tick(); idle_inputs(); settle();
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL mtlo got %h want %h", lo, 32'd9); end
    issue(4'd5, 32'h55, 32'd0);
    tick(); idle_inputs(); settle();
    checks++; if (hi !== 32'h55) begin errors++; $display("FAIL mthi got %h want %h", hi, 32'h55); end
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL mthi_lo_kept got %h want %h", lo, 32'd9); end
    $display("test_mthi_mtlo: hi=%h lo=%h", hi, lo);
    // a bubble carrying mtlo must not write
    md_op_e = 4'd6; valid_e = 1'b0; rd1_e = 32'd77;
    tick(); idle_inputs(); settle();
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL bubble_mtlo got %h want %h", lo, 32'd9); end
  endtask

  task automatic test_stall();
    tick();
    issue(4'd1, 32'd6, 32'd7); md_use_d = 1'b1; settle();
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_start got %b want 1", md_stall); end
    tick(); md_op_e = 4'd0; valid_e = 1'b0; settle();
    for (int i = 1; i <= 5; i++) begin
      checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_busy_%0d got %b want 1", i, md_stall); end
      tick(); settle();
    end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", md_stall); end
    md_use_d = 1'b0; md_op_e = 4'd8; valid_e = 1'b1; settle();
    checks++; if (ex_out_e !== 32'd42) begin errors++; $display("FAIL mflo got %h want %h", ex_out_e, 32'd42); end
    $display("test_stall: 6*7 mflo=%h hi=%h", ex_out_e, hi);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    tick();
`ifdef MDU_DIV_EN
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
`else
    issue(4'd1, 32'd11, 32'd13);
`endif
    tick(); idle_inputs();
    tick(); tick();          // now in the third busy cycle
    reset_n = 1'b0;
    tick(); reset_n = 1'b1; settle();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", md_busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h want %h", lo, 32'h0); end
    issue(4'd1, 32'd3, 32'd5);
    tick(); idle_inputs();
    repeat (5) tick();
    settle();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rstmid_mult_busy got %b want 0", md_busy); end
    checks++; if (lo !== 32'd15) begin errors++; $display("FAIL rstmid_mult_lo got %h want %h", lo, 32'd15); end
    $display("test_reset_mid: after abort and 3*5 hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back();
    tick();
    issue(4'd1, 32'd2, 32'd3);
    tick(); issue(4'd5, 32'hAAAA, 32'd0); settle();   // mthi while busy
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL b2b_mthi_start got %b want 0", md_start); end
    tick(); issue(4'd1, 32'd100, 32'd100); settle();  // mult while busy
    checks++; if (md_start !== 1'b0) begin errors++; $display("FAIL b2b_mult_start got %b want 0", md_start); end
    tick(); idle_inputs();
    tick(); tick(); tick(); settle();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", md_busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL b2b_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL b2b_lo got %h want %h", lo, 32'd6); end
    issue(4'd5, 32'hAB, 32'd0);
    tick(); idle_inputs(); settle();
    checks++; if (hi !== 32'hAB) begin errors++; $display("FAIL b2b_mthi got %h want %h", hi, 32'hAB); end
    $display("test_back_to_back: hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    reset_n = 1'b0;
    rd1_e = '0; rd2_e = '0; result_w = '0; alu_out_m = '0; ext_imm_e = '0;
    fwd_a_e = '0; fwd_b_e = '0; reg_dst_e = '0; alu_src_e = 1'b0;
    md_use_d = 1'b0; valid_e = 1'b0; alu_ctrl_e = '0; md_op_e = '0;
    rs_e = '0; rt_e = '0; rd_e = '0;
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
